// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit and its prefetch queue.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    localparam int          DEFAULT_DEPTH    = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] next_word_pc(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue holding {pc, instr} pairs; flush empties it in one cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [63:0]   push_data,
    input  logic          pop,
    output logic [63:0]   head_data,
    output logic [CW-1:0] count
);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_fifo: DEPTH must be a power of two between 2 and 16");
    end

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush;

    // Storage carries no reset; the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = (count != '0) ? mem[rd_ptr] : 64'd0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, redirect handling, prefetch queue.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [63:0]   head_data;
    logic          has_room;
    logic          push;
    logic          pop;

    assign has_room    = (count < DEPTH_C);
    assign push        = (state == ST_WAIT) && imem_ack && !redirect;
    assign instr_valid = (count != '0) && !redirect;
    assign pop         = instr_valid && instr_ready;
    assign instr_pc    = head_data[63:32];
    assign instr       = head_data[31:0];

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data ({imem_addr, imem_rdata}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    // A redirect always rewrites fetch_pc; the state decides what happens to an in-flight request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            fetch_pc  <= word_align(RESET_PC);
            imem_addr <= word_align(RESET_PC);
            imem_req  <= 1'b0;
        end else begin
            if (redirect) begin
                fetch_pc <= word_align(redirect_pc);
            end
            case (state)
                ST_RUN: begin
                    if (!redirect && has_room) begin
                        state     <= ST_WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        state    <= ST_RUN;
                        imem_req <= 1'b0;
                        if (!redirect) begin
                            fetch_pc <= next_word_pc(imem_addr);
                        end
                    end else if (redirect) begin
                        state <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (imem_ack) begin
                        state    <= ST_RUN;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, full queue, redirects, wrap and reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_ack = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        instr_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        ack2 = 1'b1;
    logic        redirect2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'd0;
    logic        ready2 = 1'b1;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic        instr_valid2;
    logic [31:0] instr2;
    logic [31:0] instr_pc2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign imem_rdata  = mem_word(imem_addr);
    assign imem_rdata2 = mem_word(imem_addr2);

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'hFFFF_FFF8)
    ) u_dut_wrap (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req2),
        .imem_addr   (imem_addr2),
        .imem_ack    (ack2),
        .imem_rdata  (imem_rdata2),
        .redirect    (redirect2),
        .redirect_pc (redirect_pc2),
        .instr_valid (instr_valid2),
        .instr       (instr2),
        .instr_pc    (instr_pc2),
        .instr_ready (ready2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        imem_ack    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        instr_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        // reset values
        step();
        step();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_addr2", imem_addr2, 32'hFFFF_FFF8);
        rst = 1'b1;

        // sequential fetch with ack always high, plus wrap on the second instance
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a;
            logic [31:0] a2;
            a  = 32'(4 * k);
            a2 = 32'hFFFF_FFF8 + 32'(4 * k);
            step();
            chk("seq_req", imem_req, 1'b1);
            chk("seq_addr", imem_addr, a);
            chk("seq_valid_lo", instr_valid, 1'b0);
            chk("wrap_addr", imem_addr2, a2);
            step();
            chk("seq_valid", instr_valid, 1'b1);
            chk("seq_pc", instr_pc, a);
            chk("seq_instr", instr, mem_word(a));
        end

        // queue fills with decode stalled, then one pop frees one slot
        do_reset();
        imem_ack = 1'b1;
        repeat (8) step();
        chk("full_valid", instr_valid, 1'b1);
        chk("full_head", instr_pc, 32'h0);
        chk("full_req", imem_req, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("full_idle_req", imem_req, 1'b0);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("pop_req", imem_req, 1'b0);
        chk("pop_head", instr_pc, 32'h4);
        step();
        chk("refill_req", imem_req, 1'b1);
        chk("refill_addr", imem_addr, 32'h10);
        step();
        chk("refill_done", imem_req, 1'b0);
        step();
        chk("refull_req", imem_req, 1'b0);

        // redirect during WAIT, ack arrives later and is discarded
        do_reset();
        instr_ready = 1'b1;
        step();
        chk("disc_req0", imem_req, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk("disc_req1", imem_req, 1'b1);
        chk("disc_addr1", imem_addr, 32'h0);
        step();
        chk("disc_addr2", imem_addr, 32'h0);
        imem_ack = 1'b1;
        step();
        chk("disc_drop_req", imem_req, 1'b0);
        chk("disc_drop_valid", instr_valid, 1'b0);
        step();
        chk("disc_new_req", imem_req, 1'b1);
        chk("disc_new_addr", imem_addr, 32'h100);
        step();
        chk("disc_valid", instr_valid, 1'b1);
        chk("disc_pc", instr_pc, 32'h100);
        chk("disc_instr", instr, mem_word(32'h100));

        // back-to-back redirects: the last one wins
        do_reset();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect_pc = 32'h407;
        step();
        redirect = 1'b0;
        imem_ack = 1'b1;
        step();
        chk("multi_req", imem_req, 1'b0);
        step();
        chk("multi_addr", imem_addr, 32'h404);

        // redirect with same-cycle ack, queue non-empty
        do_reset();
        imem_ack = 1'b1;
        step();
        step();
        step();
        chk("same_pre_valid", instr_valid, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        #1;
        chk("same_valid_redir", instr_valid, 1'b0);
        step();
        redirect = 1'b0;
        chk("same_valid", instr_valid, 1'b0);
        chk("same_req", imem_req, 1'b0);
        step();
        chk("same_new_req", imem_req, 1'b1);
        chk("same_new_addr", imem_addr, 32'h200);
        step();
        chk("same_pc", instr_pc, 32'h200);

        // reset in the middle of a request
        do_reset();
        imem_ack = 1'b1;
        step();
        step();
        imem_ack = 1'b0;
        step();
        chk("mid_req", imem_req, 1'b1);
        chk("mid_addr", imem_addr, 32'h4);
        rst = 1'b0;
        #1;
        chk("mid_rst_req", imem_req, 1'b0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_valid", instr_valid, 1'b0);
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_pc", instr_pc, 32'h0);
        imem_ack = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        chk("post_rst_addr", imem_addr, 32'h0);
        step();
        chk("post_rst_pc", instr_pc, 32'h0);
        chk("post_rst_instr", instr, mem_word(32'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
